trace_capture_ctrl: RTL and testbench
=====================================

TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning trace length in samples (power of two, >=4).
REQ-002 SHALL have parameter START_TAG, default 8'd250, meaning the byte written as sample 0 of every trace.
REQ-003 SHALL have parameter MARKER, default 8'd255, meaning the byte written instead of the sample while marker_i=1.
REQ-004 SHALL have parameter GAP_CYCLES, default 4096, meaning idle cycles after a dump before re-arming.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is posedge clk.
REQ-006 SHALL have port rstn, input, 1, reset; one clock, reset is synchronous and active-low.
REQ-007 SHALL have port trig_i, input, 1, capture start, sampled level (AES data-ready).
REQ-008 SHALL have port sample_i, input, 8, decoded TDC sensor value.
REQ-009 SHALL have port marker_i, input, 1, AES done flag; when high it replaces the sample with MARKER.
REQ-010 SHALL have port dump_i, input, 1, request to stream the captured trace.
REQ-011 SHALL have port tx_done_i, input, 1, one-cycle UART byte-complete pulse.
REQ-012 SHALL have port tx_start_o, output, 1, one-cycle UART byte-valid strobe.
REQ-013 SHALL have port tx_byte_o, output, 8, byte to transmit, stable from tx_start_o until tx_done_i.
REQ-014 SHALL have ports busy_o, full_o and overrun_o, each an output of width 1: capture in progress; trace held; sticky flag for a trigger lost while not IDLE.

Function
REQ-015 SHALL implement the states IDLE, CAPTURE, FULL, RD_ADDR, RD_STROBE, RD_WAIT and GAP.
REQ-016 IDLE: trig_i=1 -> write START_TAG at address 0, set wr_addr=1, go to CAPTURE, busy_o=1 from the next cycle.
REQ-017 CAPTURE: each cycle write (marker_i ? MARKER : sample_i) at wr_addr and increment it; after the write to DEPTH-1, go to FULL with wr_addr=0 and busy_o=0.
REQ-018 CAPTURE SHALL take exactly DEPTH cycles from the trigger cycle to the FULL entry; trig_i is ignored throughout.
REQ-019 FULL: full_o=1; dump_i=1 -> rd_addr=0, go to RD_ADDR; otherwise hold indefinitely.
REQ-020 RD_ADDR: issue a buffer read at rd_addr (1-cycle read latency), go to RD_STROBE.
REQ-021 RD_STROBE: register the read data on tx_byte_o, pulse tx_start_o for exactly 1 cycle, go to RD_WAIT.
REQ-022 RD_WAIT: on tx_done_i, if rd_addr=DEPTH-1 go to GAP with the counter cleared; else increment rd_addr and go to RD_ADDR.
REQ-023 tx_done_i outside RD_WAIT SHALL be ignored; a pulse in the same cycle as tx_start_o SHALL NOT count.
REQ-024 GAP: count GAP_CYCLES cycles, then go to IDLE; full_o SHALL clear on entry to GAP.
REQ-025 trig_i=1 in FULL, RD_* or GAP SHALL set overrun_o, which clears only on reset or on the next IDLE->CAPTURE transition.
REQ-026 dump_i outside FULL SHALL be ignored.
REQ-027 Address counters are log2(DEPTH) bits; wrap SHALL never occur because termination is tested at DEPTH-1.
REQ-028 The byte order on UART SHALL be address 0..DEPTH-1, exactly DEPTH bytes per dump.

Reset
REQ-029 rstn=0 at a clock edge SHALL force IDLE, clear both address counters and the GAP counter, and drive tx_start_o=0, tx_byte_o=0, busy_o=0, full_o=0 and overrun_o=0.
REQ-030 Reset mid-CAPTURE or mid-dump SHALL abort without emitting a further tx_start_o; buffer contents are undefined and not cleared.

Structure
REQ-031 The state encoding, START_TAG/MARKER defaults and the address-width function SHALL reside in shared package trace_pkg.
REQ-032 The buffer SHALL be sub-module trace_ram: simple dual-port, 1 write port, 1 registered read port, DEPTH x 8, inferable as block RAM, with no reset on its array.

Verification (DEPTH=16, GAP_CYCLES=8 in sim)
REQ-033 Trig with sample_i = cycle index 1..15 and marker_i=0, then dump with a 10-cycle tx_done_i responder -> bytes FA,01..0F, full_o=1 before dump, 0 after.
REQ-034 marker_i=1 on the 5th and 6th capture cycles -> bytes 4 and 5 of the dump are FF, all others are sample values.
REQ-035 trig_i held high for 40 cycles -> exactly one capture, overrun_o=1 after FULL, and overrun_o=0 after the next trigger from IDLE.
REQ-036 rstn=0 during RD_WAIT at byte 7 -> no further tx_start_o, all outputs 0 the next cycle, and a new trigger works normally.
REQ-037 A spurious tx_done_i in FULL and in RD_STROBE -> no address advance and the byte count remains 16.
REQ-038 dump_i pulsed in IDLE and CAPTURE -> no tx_start_o; after GAP completes (8 cycles) trig_i is accepted again.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and defaults for the trace capture controller and its buffer.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_FULL      = 3'd2,
        ST_RD_ADDR   = 3'd3,
        ST_RD_STROBE = 3'd4,
        ST_RD_WAIT   = 3'd5,
        ST_GAP       = 3'd6
    } trace_state_t;

    localparam int         TRACE_DEF_DEPTH = 2048;
    localparam logic [7:0] TRACE_START_TAG = 8'd250;
    localparam logic [7:0] TRACE_MARKER    = 8'd255;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int trace_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_ram_if.sv
// Buffer access bundle: one write port and one registered read port.
interface trace_ram_if
    import trace_pkg::*;
#(
    parameter int AW = trace_addr_w(TRACE_DEF_DEPTH),
    parameter int DW = 8
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    modport master (output we, waddr, wdata, re, raddr, input rdata);
    modport slave  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace buffer with a registered read; the array is never
// reset so it maps onto block RAM.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEF_DEPTH,
    parameter int DW    = 8
)(
    input  logic        clk,
    trace_ram_if.slave  bus
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (bus.we) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
        if (bus.re) begin
            r_rdata <= r_mem[bus.raddr];
        end
    end

    assign bus.rdata = r_rdata;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Captures one DEPTH-sample trace per trigger into trace_ram, then streams it
// byte by byte to a UART on request, followed by a hold-off gap.
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int         DEPTH      = TRACE_DEF_DEPTH,
    parameter logic [7:0] START_TAG  = TRACE_START_TAG,
    parameter logic [7:0] MARKER     = TRACE_MARKER,
    parameter int         GAP_CYCLES = 4096
)(
    input  logic       clk,
    input  logic       rstn,
    input  logic       trig_i,
    input  logic [7:0] sample_i,
    input  logic       marker_i,
    input  logic       dump_i,
    input  logic       tx_done_i,
    output logic       tx_start_o,
    output logic [7:0] tx_byte_o,
    output logic       busy_o,
    output logic       full_o,
    output logic       overrun_o
);

    localparam int            AW        = trace_addr_w(DEPTH);
    localparam int            GW        = trace_addr_w(GAP_CYCLES);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    trace_state_t  r_state;
    trace_state_t  w_state_next;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_rd_addr;
    logic [GW-1:0] r_gap_cnt;
    logic          r_tx_start;
    logic [7:0]    r_tx_byte;
    logic          r_overrun;

    logic          w_trig_accept;
    logic          w_done_ok;
    logic          w_busy;
    logic          w_full;
    logic          w_we;
    logic [7:0]    w_wdata;
    logic          w_re;

    trace_ram_if #(.AW(AW), .DW(8)) w_ram_bus();

    trace_ram #(.DEPTH(DEPTH), .DW(8)) u_ram (
        .clk (clk),
        .bus (w_ram_bus.slave)
    );

    assign w_trig_accept = (r_state == ST_IDLE) && trig_i;
    // A completion arriving alongside our own strobe belongs to an older byte.
    assign w_done_ok     = (r_state == ST_RD_WAIT) && tx_done_i && !r_tx_start;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (trig_i) w_state_next = ST_CAPTURE;
            ST_CAPTURE:   if (r_wr_addr == ADDR_LAST) w_state_next = ST_FULL;
            ST_FULL:      if (dump_i) w_state_next = ST_RD_ADDR;
            ST_RD_ADDR:   w_state_next = ST_RD_STROBE;
            ST_RD_STROBE: w_state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (w_done_ok) begin
                    w_state_next = (r_rd_addr == ADDR_LAST) ? ST_GAP : ST_RD_ADDR;
                end
            end
            ST_GAP:       if (r_gap_cnt == GAP_LAST) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == ST_CAPTURE);
        w_full  = (r_state == ST_FULL)      || (r_state == ST_RD_ADDR) ||
                  (r_state == ST_RD_STROBE) || (r_state == ST_RD_WAIT);
        w_we    = w_trig_accept || (r_state == ST_CAPTURE);
        w_wdata = START_TAG;
        if (r_state == ST_CAPTURE) begin
            w_wdata = marker_i ? MARKER : sample_i;
        end
        w_re    = (r_state == ST_RD_ADDR);
    end

    // The write address rests at zero outside CAPTURE, so the start tag lands at 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_gap_cnt  <= '0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            r_tx_start <= (r_state == ST_RD_STROBE);
            if (r_state == ST_RD_STROBE) begin
                r_tx_byte <= w_ram_bus.rdata;
            end

            if (w_trig_accept) begin
                r_wr_addr <= AW'(1);
            end else if (r_state == ST_CAPTURE) begin
                r_wr_addr <= (r_wr_addr == ADDR_LAST) ? '0 : r_wr_addr + AW'(1);
            end

            if ((r_state == ST_FULL) && dump_i) begin
                r_rd_addr <= '0;
            end else if (w_done_ok && (r_rd_addr != ADDR_LAST)) begin
                r_rd_addr <= r_rd_addr + AW'(1);
            end

            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;

            if (w_trig_accept) begin
                r_overrun <= 1'b0;
            end else if (trig_i && (r_state != ST_IDLE) && (r_state != ST_CAPTURE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_ram_bus.we    = w_we;
    assign w_ram_bus.waddr = r_wr_addr;
    assign w_ram_bus.wdata = w_wdata;
    assign w_ram_bus.re    = w_re;
    assign w_ram_bus.raddr = r_rd_addr;

    assign tx_start_o = r_tx_start;
    assign tx_byte_o  = r_tx_byte;
    assign busy_o     = w_busy;
    assign full_o     = w_full;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl (DEPTH=16, GAP_CYCLES=8) plus a direct
// check of the trace_ram buffer through its interface.
module tb_trace_capture_ctrl;

    localparam int DEPTH = 16;
    localparam int GAPC  = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       trig_i;
    logic [7:0] sample_i;
    logic       marker_i;
    logic       dump_i;
    logic       tx_done_i;
    logic       tx_start_o;
    logic [7:0] tx_byte_o;
    logic       busy_o;
    logic       full_o;
    logic       overrun_o;

    logic       done_resp;
    logic       done_spur;
    logic       resp_en;
    logic [7:0] rx_q [$];
    int         total = 0;
    int         bad   = 0;

    typedef struct {
        logic [15:0]  mask;
        logic [7:0]   add;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;
    assign tx_done_i = done_resp | done_spur;

    trace_capture_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAPC)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .trig_i     (trig_i),
        .sample_i   (sample_i),
        .marker_i   (marker_i),
        .dump_i     (dump_i),
        .tx_done_i  (tx_done_i),
        .tx_start_o (tx_start_o),
        .tx_byte_o  (tx_byte_o),
        .busy_o     (busy_o),
        .full_o     (full_o),
        .overrun_o  (overrun_o)
    );

    trace_ram_if #(.AW(4), .DW(8)) ram_bus();
    trace_ram #(.DEPTH(DEPTH), .DW(8)) u_ram (
        .clk (clk),
        .bus (ram_bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (tx_start_o) rx_q.push_back(tx_byte_o);
    end

    // UART model: byte-complete pulse 10 cycles after each strobe.
    initial begin
        logic [7:0] held;
        done_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && tx_start_o) begin
                held = tx_byte_o;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (!resp_en) break;
                end
                if (resp_en) begin
                    done_resp = 1'b1;
                    check("tx_byte_stable", {24'h0, tx_byte_o}, {24'h0, held});
                    tick();
                    done_resp = 1'b0;
                end
            end
        end
    end

    task automatic do_capture(input logic [15:0] mask, input logic [7:0] add, input int dump_at);
        int bcnt;
        bcnt     = 0;
        trig_i   = 1'b1;
        marker_i = 1'b0;
        sample_i = 8'h00;
        tick();
        trig_i = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (busy_o) bcnt++;
            sample_i = 8'(k) + add;
            marker_i = mask[k];
            dump_i   = (k == dump_at);
            tick();
        end
        dump_i   = 1'b0;
        marker_i = 1'b0;
        check("capture_busy_cycles", bcnt, DEPTH - 1);
        check("full_after_capture", full_o, 1);
        check("busy_after_capture", busy_o, 0);
    endtask

    task automatic do_dump(input logic [127:0] exp, input bit spur, input string tag);
        int cyc;
        rx_q.delete();
        resp_en = 1'b1;
        dump_i  = 1'b1;
        tick();
        dump_i = 1'b0;
        if (spur) begin
            tick();
            done_spur = 1'b1;
            tick();
            tick();
            done_spur = 1'b0;
        end
        cyc = 0;
        while (!(rx_q.size() >= DEPTH && !full_o) && cyc < 800) begin
            tick();
            cyc++;
        end
        check({tag, "_finished"}, (cyc < 800), 1);
        check({tag, "_len"}, rx_q.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < rx_q.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k), {24'h0, rx_q[k]}, {24'h0, exp[8*k +: 8]});
        end
        check({tag, "_full_cleared"}, full_o, 0);
        resp_en = 1'b0;
        $display("dump %s: %0d bytes received after %0d cycles", tag, rx_q.size(), cyc);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h0000, 8'h00, 128'h0F0E0D0C_0B0A0908_07060504_030201FA};
        vecs[1] = '{16'h0030, 8'h00, 128'h0F0E0D0C_0B0A0908_0706FFFF_030201FA};
        vecs[2] = '{16'h8002, 8'h40, 128'hFF4E4D4C_4B4A4948_47464544_4342FFFA};
        vecs[3] = '{16'h0000, 8'hF0, 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1FA};

        rstn = 1'b0; trig_i = 1'b0; sample_i = 8'h00; marker_i = 1'b0;
        dump_i = 1'b0; done_spur = 1'b0; resp_en = 1'b0;
        ram_bus.we = 1'b0; ram_bus.re = 1'b0; ram_bus.waddr = '0;
        ram_bus.raddr = '0; ram_bus.wdata = '0;
        tick(); tick(); tick();
        check("rst_tx_start", tx_start_o, 0);
        check("rst_tx_byte", tx_byte_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_full", full_o, 0);
        check("rst_overrun", overrun_o, 0);
        rstn = 1'b1;
        tick();

        // Buffer alone: writes, registered reads, read data held while re=0.
        ram_bus.we = 1'b1;
        ram_bus.waddr = 4'd3;  ram_bus.wdata = 8'hA5; tick();
        ram_bus.waddr = 4'd9;  ram_bus.wdata = 8'h5A; tick();
        ram_bus.waddr = 4'd15; ram_bus.wdata = 8'hC3; tick();
        ram_bus.we = 1'b0;
        ram_bus.re = 1'b1; ram_bus.raddr = 4'd9; tick();
        check("ram_rd9", ram_bus.rdata, 8'h5A);
        ram_bus.re = 1'b0; ram_bus.raddr = 4'd3; tick();
        check("ram_hold", ram_bus.rdata, 8'h5A);
        ram_bus.re = 1'b1; tick();
        check("ram_rd3", ram_bus.rdata, 8'hA5);
        ram_bus.raddr = 4'd15; tick();
        check("ram_rd15", ram_bus.rdata, 8'hC3);
        ram_bus.re = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_capture(vecs[v].mask, vecs[v].add, 0);
            do_dump(vecs[v].exp, 1'b0, $sformatf("vec%0d", v));
            repeat (GAPC + 2) tick();
        end

        // Stray completions in FULL, in RD_STROBE and alongside the strobe.
        do_capture(16'h0000, 8'h00, 0);
        done_spur = 1'b1; tick(); done_spur = 1'b0; tick();
        check("full_after_spur", full_o, 1);
        do_dump(vecs[0].exp, 1'b1, "spur");
        repeat (GAPC + 2) tick();

        // Trigger held for 40 cycles: one capture, then overrun.
        trig_i = 1'b1; sample_i = 8'h00; n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy_o) n++;
            sample_i = 8'(i);
        end
        trig_i = 1'b0;
        check("held_trig_busy_cycles", n, DEPTH - 1);
        check("held_trig_full", full_o, 1);
        check("held_trig_overrun", overrun_o, 1);
        do_dump(vecs[0].exp, 1'b0, "held");
        repeat (GAPC + 2) tick();
        check("overrun_sticky_idle", overrun_o, 1);
        do_capture(16'h0000, 8'h00, 0);
        check("overrun_cleared_by_trig", overrun_o, 0);
        do_dump(vecs[0].exp, 1'b0, "after_overrun");
        repeat (GAPC + 2) tick();

        // Reset while waiting on byte 7.
        do_capture(16'h0000, 8'h10, 0);
        rx_q.delete();
        resp_en = 1'b1; dump_i = 1'b1; tick(); dump_i = 1'b0;
        n = 0;
        while (rx_q.size() < 8 && n < 300) begin tick(); n++; end
        check("reached_byte7", rx_q.size(), 8);
        tick(); tick();
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        check("overrun_during_dump", overrun_o, 1);
        rstn = 1'b0; resp_en = 1'b0; tick();
        check("outputs_after_reset", {tx_start_o, tx_byte_o, busy_o, full_o, overrun_o}, 12'h000);
        rstn = 1'b1;
        repeat (30) tick();
        check("no_tx_after_reset", rx_q.size(), 8);
        $display("reset mid-dump: %0d bytes before abort", rx_q.size());
        do_capture(16'h0000, 8'h00, 0);
        do_dump(vecs[0].exp, 1'b0, "post_reset");
        repeat (GAPC + 2) tick();

        // Dump requests outside FULL, then the re-arm delay after GAP.
        rx_q.delete();
        dump_i = 1'b1; tick(); dump_i = 1'b0;
        repeat (5) tick();
        check("idle_dump_ignored", rx_q.size(), 0);
        check("idle_dump_busy", busy_o, 0);
        do_capture(16'h0030, 8'h00, 3);
        repeat (5) tick();
        check("capture_dump_ignored", rx_q.size(), 0);
        check("capture_dump_still_full", full_o, 1);
        do_dump(vecs[1].exp, 1'b0, "gap_test");
        trig_i = 1'b1; n = 0;
        while (!busy_o && n < 20) begin tick(); n++; end
        trig_i = 1'b0;
        check("gap_rearm_cycles", n, GAPC + 1);
        check("gap_rearm_overrun", overrun_o, 0);
        $display("re-armed %0d cycles after GAP entry", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
